// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller between the core datapath and a word-wide dmem array.
// Sub-word stores are read-modify-write; loads return sign/zero-extended data.
module lsu_dmem_ctrl #(
  parameter int unsigned Width = 32,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             resp_valid,
  output logic [Width-1:0] resp_rdata,
  output logic             resp_err,
  output logic             dm_we,
  output logic [AW-1:0]    dm_a,
  output logic [Width-1:0] dm_wd,
  input  logic [Width-1:0] dm_rd
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  state_e state_q, state_d;

  // Only the in-range part of the address is kept; upper bits matter only for the error check.
  logic [AW+1:0]    addr_q;
  logic [2:0]       funct3_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] merged_q;
  logic [Width-1:0] rdata_q;
  logic             err_q;

  logic             accept;
  logic             req_err;
  logic [Width-1:0] load_data;
  logic [Width-1:0] merge_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    req_err = |req_addr[31:AW+2];
    if (req_we) begin
      case (req_funct3)
        3'b000:  ;
        3'b001:  req_err = req_err | req_addr[0];
        3'b010:  req_err = req_err | (|req_addr[1:0]);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: ;
        3'b001, 3'b101: req_err = req_err | req_addr[0];
        3'b010:         req_err = req_err | (|req_addr[1:0]);
        default:        req_err = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3[1]) begin
            state_d = StWrite;
          end else begin
            state_d = StMerge;
          end
        end
      end
      StLoad:  state_d = StResp;
      StMerge: state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    // Gated by reset so an abandoned store never reaches dmem on the reset edge.
    dm_we      = (state_q == StWrite) && reset_n;
    dm_a       = addr_q[AW+1:2];
    dm_wd      = funct3_q[1] ? wdata_q : merged_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Little-endian lane selection and extension for loads
  always_comb begin
    ld_byte   = dm_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half   = dm_rd[{addr_q[1], 4'b0000} +: 16];
    load_data = dm_rd;
    case (funct3_q)
      3'b000:  load_data = {{(Width-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(Width-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(Width-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(Width-16){1'b0}}, ld_half};
      default: load_data = dm_rd;
    endcase
  end

  always_comb begin
    merge_word = dm_rd;
    if (funct3_q[0]) begin
      merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Request and response datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr[AW+1:0];
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state_q == StLoad) begin
        rdata_q <= load_data;
      end
      if (state_q == StMerge) begin
        merged_q <= merge_word;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a behavioural dmem array.
// Directed requests push expected responses; a negedge monitor checks them.
module tb_lsu_dmem_ctrl;

  localparam int unsigned Width = 32;
  localparam int unsigned AW    = 7;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [Width-1:0] req_wdata;
  logic             resp_valid;
  logic [Width-1:0] resp_rdata;
  logic             resp_err;
  logic             dm_we;
  logic [AW-1:0]    dm_a;
  logic [Width-1:0] dm_wd;
  logic [Width-1:0] dm_rd;

  lsu_dmem_ctrl #(.Width(Width), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_we      (dm_we),
    .dm_a       (dm_a),
    .dm_wd      (dm_wd),
    .dm_rd      (dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [Width-1:0] mem [2**AW];
  int               we_cnt;
  logic [AW-1:0]    last_wa;
  int               cyc;

  assign dm_rd = mem[dm_a];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_we) begin
      mem[dm_a] <= dm_wd;
      we_cnt    <= we_cnt + 1;
      last_wa   <= dm_a;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 want no response pending");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.name, "_lat"}, cyc + 1 - e.acc, e.lat);
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic er, input int lat, input string nm);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.lat   = lat;
    e.acc   = cyc;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input string nm);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL %s_ready_timeout: got req_ready=0 want 1", nm);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    push_exp(exp_rd, exp_err, exp_lat, nm);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  int we0;
  int a1;
  int a2;
  int rv_seen;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks     = 0;
    fails      = 0;
    we_cnt     = 0;
    last_wa    = '0;
    cyc        = 0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_a", {25'd0, dm_a}, 32'd0);

    // Word store then load back
    we0 = we_cnt;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_10");
    drain();
    chk("sw_we_count", we_cnt - we0, 32'd1);
    chk("sw_we_addr", {25'd0, last_wa}, 32'd4);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_10_a");
    drain();

    // Byte store and byte loads
    issue(1'b1, 3'b000, 32'h12, 32'h12345655, 32'h0, 1'b0, 3, "sb_12");
    drain();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 2, "lw_10_b");
    drain();
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, "lb_13");
    drain();
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, "lbu_13");
    drain();

    // Halfword store and halfword loads
    issue(1'b1, 3'b001, 32'h10, 32'hABCD8001, 32'h0, 1'b0, 3, "sh_10");
    drain();
    issue(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF8001, 1'b0, 2, "lh_10");
    drain();
    issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h00008001, 1'b0, 2, "lhu_10");
    drain();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE558001, 1'b0, 2, "lw_10_c");
    drain();
    issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h00000001, 1'b0, 2, "lb_10");
    drain();
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDE55, 1'b0, 2, "lh_12");
    drain();

    // Error requests: immediate response, no writes
    we0 = we_cnt;
    issue(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1, "err_lh_11");
    drain();
    issue(1'b1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1'b1, 1, "err_sw_12");
    drain();
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 1, "err_lw_200");
    drain();
    issue(1'b1, 3'b000, 32'h200, 32'h22222222, 32'h0, 1'b1, 1, "err_sb_200");
    drain();
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "err_ld_f3_011");
    drain();
    issue(1'b1, 3'b100, 32'h10, 32'h33333333, 32'h0, 1'b1, 1, "err_st_f3_100");
    drain();
    chk("err_no_write", we_cnt - we0, 32'd0);
    chk("err_mem4", mem[4], 32'hDE558001);
    chk("err_mem0", mem[0], 32'h0);

    // req_valid held through a load: exactly one accept per 3 cycles
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = '0;
    @(posedge clk);
    #1;
    a1 = cyc;
    push_exp(32'hDE558001, 1'b0, 2, "hold_lw_1");
    @(negedge clk);
    chk("hold_ready_c1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("hold_ready_c2", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("hold_ready_c3", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    a2 = cyc;
    push_exp(32'hDE558001, 1'b0, 2, "hold_lw_2");
    req_valid = 1'b0;
    chk("hold_period", a2 - a1, 32'd3);
    @(negedge clk);
    drain();

    // Reset during the WRITE of an SB: store abandoned
    we0 = we_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    req_wdata  = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_in_write", {31'd0, dm_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstw_we_gated", {31'd0, dm_we}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_resp_rdata", resp_rdata, 32'd0);
    chk("rstw_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rstw_dm_a", {25'd0, dm_a}, 32'd0);
    chk("rstw_no_write", we_cnt - we0, 32'd0);
    chk("rstw_mem4", mem[4], 32'hDE558001);
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    chk("rstw_no_resp", rv_seen, 32'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE558001, 1'b0, 2, "rstw_lw");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store controller between the multicycle core datapath and the word-wide `dmem` array. It accepts one memory request at a time over a valid/ready handshake. It performs RV32I byte, halfword and word accesses, using read-modify-write for sub-word stores because `dmem` only writes whole words. It returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- `Width`, 32, data word width; must equal the `dmem` `Width`.
- `AW`, 7, `dmem` word-address width, giving 2^AW words and a 2^(AW+2)-byte space.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request (IDLE only).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  Width  store data; low bits are used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  Width  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned, out-of-range or illegal funct3; valid with `resp_valid`.
- `dm_we`  out  1  to `dmem` `we`.
- `dm_a`  out  AW  to `dmem` `a`; word index.
- `dm_wd`  out  Width  to `dmem` `wd`.
- `dm_rd`  in  Width  from `dmem` `rd`; combinational read of `dm_a`.

## Operation
- The request is accepted on a rising edge where `req_valid && req_ready`.
- On acceptance, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- `dm_a` = latched `addr[AW+1:2]`, driven from the register in every state.
- Error is set when any of the following holds (check at accept):
  - `addr[31:AW+2] != 0`;
  - halfword access with `addr[0]=1`;
  - word access with `addr[1:0]!=0`;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010}.
- On error, go directly to RESP with `resp_err=1` and `resp_rdata=0`; `dmem` is never written.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
  - IDLE: `req_ready=1`. On accept, go to RESP on error, LOAD for a load, WRITE for SW, MERGE for SB/SH.
  - LOAD: select the byte/half from `dm_rd` using `addr[1:0]`. Sign-extend for LB/LH; zero-extend for LBU/LHU; LW is unchanged. Register the result into `resp_rdata`, then go to RESP.
  - MERGE: register the merged word = `dm_rd` with the addressed byte (SB, lane `addr[1:0]`) or halfword (SH, lane `addr[1]`) replaced by the low bits of `req_wdata`. Then go to WRITE.
  - WRITE: `dm_we=1`. `dm_wd` = merged word for SB/SH, or latched `req_wdata` for SW. Go to RESP.
  - RESP: `resp_valid=1` for exactly one cycle, then go to IDLE. There is no back-pressure on the response.
- Byte lanes are little-endian: byte 0 = bits [7:0].
- `dm_we = (state==WRITE) && reset_n`. No write occurs on an edge where `reset_n` is low.
- `req_valid` in any state other than IDLE is ignored; it is not queued.

## Timing
- Reset: state=IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `dm_we=0`, address/data registers 0.
- Accept edge = T. `resp_valid` goes high in the cycle after edge:
  - loads: T+2;
  - SW: T+2, with the `dmem` write at edge T+2;
  - SB/SH: T+3, with the write at edge T+3;
  - error: T+1.
- Throughput: the next accept is possible in the cycle after `resp_valid` (IDLE), so the load-to-load period is 3 cycles.
- A load issued after a store sees the stored data, because the write completes before RESP.
- Reset asserted mid-operation (any state) returns to IDLE at that edge. A pending MERGE/WRITE is abandoned and `dmem` is unchanged. `resp_valid` is not emitted for the aborted request.
- `resp_rdata`/`resp_err` hold their values from RESP until the next RESP; they are cleared to 0 on the next accept.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW 0x10: `dm_we` pulses once with `dm_a=4`. Load response comes 2 cycles after accept with `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- After that word, SB 0x55 to 0x12, then LW 0x10 returns 0xDE55BEEF. LB 0x13 returns 0xFFFFFFDE; LBU 0x13 returns 0x000000DE.
- SH 0x8001 to 0x10, then LH 0x10 returns 0xFFFF8001 and LHU returns 0x00008001. The upper half is preserved: LW returns 0xDE558001.
- Misaligned and illegal requests: LH 0x11, SW 0x12, an access at 0x200 (AW=7), and load funct3=011. Each gets `resp_valid` at T+1 with `resp_err=1`, `resp_rdata=0`, `dm_we` never high, and memory unchanged.
- `req_valid` held high through a load: only one accept occurs, `req_ready` is low for 2 cycles, and the next request is accepted in the cycle after `resp_valid`.
- SB issued, then `reset_n` low during the WRITE cycle: no `dmem` write occurs, all outputs are at reset values next cycle, no `resp_valid`, and a subsequent LW returns the old word.
